exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 19, giving the one-hot ALU opcode width; bit 15 is divu and bit 16 is modu.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port ds_to_es_valid, input, 1, decode stage offers an instruction.
REQ-005 SHALL have port es_allowin, output, 1, this stage accepts ds data this cycle.
REQ-006 SHALL have ports ds_alu_op (input, ALU_OP_W), ds_src1 and ds_src2 (input, 32 each), ds_dest (input, 5) and ds_pc (input, 32), the instruction payload.
REQ-007 SHALL have ports es_alu_op (output, ALU_OP_W) and es_alu_src1 and es_alu_src2 (output, 32 each), driving the ALU.
REQ-008 SHALL have ports alu_result (input, 32) and alu_ready (input, 1), ALU outputs.
REQ-009 SHALL have ports es_to_ms_valid (output, 1) and ms_allowin (input, 1), the memory-stage handshake.
REQ-010 SHALL have ports es_result (output, 32), es_dest (output, 5) and es_pc (output, 32), the payload to the memory stage.
REQ-011 SHALL have ports wb_ex, wb_ertn_flush and wb_need_refetch (input, 1 each); their OR is "flush".
REQ-012 SHALL have ports es_fwd_valid (output, 1), es_fwd_dest (output, 5) and es_fwd_data (output, 32), the bypass to decode.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE and DRAIN.
REQ-014 SHALL drive es_allowin = IDLE | (BUSY & alu_ready & ms_allowin) | (DONE & ms_allowin), and hold it low in DRAIN.
REQ-015 SHALL accept when ds_to_es_valid & es_allowin & !flush: latch op, src1, src2, dest and pc, then go to BUSY.
REQ-016 SHALL, on completion without a new accept, go to IDLE.
REQ-017 SHALL drive es_alu_op = latched op in BUSY or DRAIN, and all zeros otherwise; es_alu_src1/2 SHALL always be the latched operands.
REQ-018 SHALL drive es_to_ms_valid = (BUSY & alu_ready) | DONE, forced 0 in any cycle where flush=1.
REQ-019 SHALL drive es_result = alu_result in BUSY and the result register in DONE; es_dest and es_pc SHALL be the latched values.
REQ-020 SHALL, in BUSY with alu_ready & !ms_allowin, latch alu_result into the result register and go to DONE; the divider ready pulse SHALL NOT be lost.
REQ-021 SHALL give single-cycle ops a latency of 1 cycle from accept edge to es_to_ms_valid; divide latency equals the ALU latency.
REQ-022 SHALL apply flush with highest priority: from BUSY with latched op bit 15 or 16 set and alu_ready=0, go to DRAIN; from any other BUSY case or DONE, go to IDLE.
REQ-023 SHALL, in DRAIN, keep driving the unsigned-divide op, ignore flush and ds input, and go to IDLE in the cycle after alu_ready=1, discarding the result.
REQ-024 SHALL NOT drain signed div/mod (bits 17/18); the ALU clears that path itself on flush.
REQ-025 SHALL, on simultaneous completion, ms_allowin and a new accept, go from BUSY or DONE directly to BUSY with the new payload.

Reset
REQ-026 SHALL, on reset, force IDLE and zero all payload and result registers.
REQ-027 SHALL hold these output values in reset: es_allowin=1, es_to_ms_valid=0, es_alu_op=0, es_fwd_valid=0.
REQ-028 SHALL give reset priority over flush and accept, including mid-divide and in DRAIN.

Configuration
REQ-029 SHALL, with macro ES_RESULT_BYPASS_EN defined, drive es_fwd_valid = es_to_ms_valid & (es_dest!=0), es_fwd_dest = es_dest and es_fwd_data = es_result.
REQ-030 SHALL, with ES_RESULT_BYPASS_EN undefined, tie es_fwd_valid, es_fwd_dest and es_fwd_data to 0; no other behaviour changes.

Verification
REQ-031 SHALL cover add: src1=5, src2=7, ms_allowin=1 -> es_to_ms_valid=1 and es_result=12 in the cycle after accept, es_allowin=1 throughout.
REQ-032 SHALL cover divu with ms stall: src1=100, src2=7, ms_allowin=0 at the ready pulse -> DONE; es_result holds 14 until ms_allowin=1, then one transfer.
REQ-033 SHALL cover flush mid-divu: wb_ex pulses 3 cycles after accept -> DRAIN, es_allowin=0, no es_to_ms_valid; IDLE after alu_ready; then a divu 9/2 yields 4.
REQ-034 SHALL cover flush mid-div (signed): -9/2 then flush -> IDLE next cycle; next op or with 0x0F/0xF0 yields 0xFF.
REQ-035 SHALL cover back-to-back ops: three adds with ms_allowin=1 -> three consecutive valid cycles, no bubbles.
REQ-036 SHALL cover reset mid-divu: reset asserted in BUSY -> next cycle IDLE, es_allowin=1 and es_alu_op=0.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: decode/memory handshake, ALU drive, divider drain on flush.
// Optional result bypass to decode enabled by ES_RESULT_BYPASS_EN.
module exe_stage #(
  parameter int ALU_OP_W = 19
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ds_to_es_valid,
  output logic                es_allowin,
  input  logic [ALU_OP_W-1:0] ds_alu_op,
  input  logic [31:0]         ds_src1,
  input  logic [31:0]         ds_src2,
  input  logic [4:0]          ds_dest,
  input  logic [31:0]         ds_pc,
  output logic [ALU_OP_W-1:0] es_alu_op,
  output logic [31:0]         es_alu_src1,
  output logic [31:0]         es_alu_src2,
  input  logic [31:0]         alu_result,
  input  logic                alu_ready,
  output logic                es_to_ms_valid,
  input  logic                ms_allowin,
  output logic [31:0]         es_result,
  output logic [4:0]          es_dest,
  output logic [31:0]         es_pc,
  input  logic                wb_ex,
  input  logic                wb_ertn_flush,
  input  logic                wb_need_refetch,
  output logic                es_fwd_valid,
  output logic [4:0]          es_fwd_dest,
  output logic [31:0]         es_fwd_data
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    DRAIN
  } state_t;

  state_t              state;
  logic [ALU_OP_W-1:0] op_r;
  logic [31:0]         src1_r;
  logic [31:0]         src2_r;
  logic [31:0]         pc_r;
  logic [31:0]         res_r;
  logic [4:0]          dest_r;

  logic flush;
  logic accept;
  logic udiv;
  logic st_idle;
  logic st_busy;
  logic st_done;
  logic st_drain;

  assign st_idle  = (state == IDLE);
  assign st_busy  = (state == BUSY);
  assign st_done  = (state == DONE);
  assign st_drain = (state == DRAIN);

  assign flush = wb_ex | wb_ertn_flush | wb_need_refetch;
  assign udiv  = op_r[15] | op_r[16];

  assign es_allowin = st_idle
                    | (st_busy & alu_ready & ms_allowin)
                    | (st_done & ms_allowin);

  assign accept = ds_to_es_valid & es_allowin & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_r   <= '0;
      src1_r <= '0;
      src2_r <= '0;
      dest_r <= '0;
      pc_r   <= '0;
      res_r  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) state <= BUSY;
        end
        BUSY: begin
          // An unsigned divider cannot be aborted; wait out its ready pulse.
          if (flush) begin
            state <= (udiv && !alu_ready) ? DRAIN : IDLE;
          end else if (alu_ready && !ms_allowin) begin
            state <= DONE;
            res_r <= alu_result;
          end else if (alu_ready) begin
            state <= accept ? BUSY : IDLE;
          end
        end
        DONE: begin
          if (flush) state <= IDLE;
          else if (ms_allowin) state <= accept ? BUSY : IDLE;
        end
        DRAIN: begin
          if (alu_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        op_r   <= ds_alu_op;
        src1_r <= ds_src1;
        src2_r <= ds_src2;
        dest_r <= ds_dest;
        pc_r   <= ds_pc;
      end
    end
  end

  assign es_alu_op   = (st_busy | st_drain) ? op_r : '0;
  assign es_alu_src1 = src1_r;
  assign es_alu_src2 = src2_r;

  assign es_to_ms_valid = ((st_busy & alu_ready) | st_done) & ~flush;

  assign es_result = st_busy ? alu_result : res_r;
  assign es_dest   = dest_r;
  assign es_pc     = pc_r;

`ifdef ES_RESULT_BYPASS_EN
  assign es_fwd_valid = es_to_ms_valid & (es_dest != 5'd0);
  assign es_fwd_dest  = es_dest;
  assign es_fwd_data  = es_result;
`else
  assign es_fwd_valid = 1'b0;
  assign es_fwd_dest  = 5'd0;
  assign es_fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with a behavioural ALU
// (single-cycle ops, 8-cycle divider, signed divider cleared on flush).
module tb_exe_stage;

  localparam int W       = 19;
  localparam int DIV_LAT = 8;

  localparam logic [W-1:0] OP_ADD  = 19'(1) << 0;
  localparam logic [W-1:0] OP_OR   = 19'(1) << 6;
  localparam logic [W-1:0] OP_DIVU = 19'(1) << 15;
  localparam logic [W-1:0] OP_MODU = 19'(1) << 16;
  localparam logic [W-1:0] OP_DIV  = 19'(1) << 17;
  localparam logic [W-1:0] OP_MOD  = 19'(1) << 18;
  localparam logic [W-1:0] DIVMASK = OP_DIVU | OP_MODU | OP_DIV | OP_MOD;

  logic         clk = 1'b0;
  logic         reset;
  logic         ds_to_es_valid;
  logic         es_allowin;
  logic [W-1:0] ds_alu_op;
  logic [31:0]  ds_src1;
  logic [31:0]  ds_src2;
  logic [4:0]   ds_dest;
  logic [31:0]  ds_pc;
  logic [W-1:0] es_alu_op;
  logic [31:0]  es_alu_src1;
  logic [31:0]  es_alu_src2;
  logic [31:0]  alu_result;
  logic         alu_ready;
  logic         es_to_ms_valid;
  logic         ms_allowin;
  logic [31:0]  es_result;
  logic [4:0]   es_dest;
  logic [31:0]  es_pc;
  logic         wb_ex;
  logic         wb_ertn_flush;
  logic         wb_need_refetch;
  logic         es_fwd_valid;
  logic [4:0]   es_fwd_dest;
  logic [31:0]  es_fwd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage #(.ALU_OP_W(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .ds_to_es_valid  (ds_to_es_valid),
    .es_allowin      (es_allowin),
    .ds_alu_op       (ds_alu_op),
    .ds_src1         (ds_src1),
    .ds_src2         (ds_src2),
    .ds_dest         (ds_dest),
    .ds_pc           (ds_pc),
    .es_alu_op       (es_alu_op),
    .es_alu_src1     (es_alu_src1),
    .es_alu_src2     (es_alu_src2),
    .alu_result      (alu_result),
    .alu_ready       (alu_ready),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .es_result       (es_result),
    .es_dest         (es_dest),
    .es_pc           (es_pc),
    .wb_ex           (wb_ex),
    .wb_ertn_flush   (wb_ertn_flush),
    .wb_need_refetch (wb_need_refetch),
    .es_fwd_valid    (es_fwd_valid),
    .es_fwd_dest     (es_fwd_dest),
    .es_fwd_data     (es_fwd_data)
  );

  // Behavioural ALU
  logic [3:0] div_cnt;
  logic       is_div;
  logic       tb_flush;

  assign is_div   = |(es_alu_op & DIVMASK);
  assign tb_flush = wb_ex | wb_ertn_flush | wb_need_refetch;

  always_comb begin
    alu_ready = is_div ? (div_cnt == 4'(DIV_LAT - 1)) : (es_alu_op != '0);
    alu_result = 32'd0;
    unique case (1'b1)
      es_alu_op[0]:  alu_result = es_alu_src1 + es_alu_src2;
      es_alu_op[6]:  alu_result = es_alu_src1 | es_alu_src2;
      es_alu_op[15]: alu_result = es_alu_src1 / es_alu_src2;
      es_alu_op[16]: alu_result = es_alu_src1 % es_alu_src2;
      es_alu_op[17]: alu_result = $signed(es_alu_src1) / $signed(es_alu_src2);
      es_alu_op[18]: alu_result = $signed(es_alu_src1) % $signed(es_alu_src2);
      default:       alu_result = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (reset) div_cnt <= '0;
    else if (is_div && !(tb_flush && |(es_alu_op & (OP_DIV | OP_MOD))))
      div_cnt <= alu_ready ? 4'd0 : div_cnt + 4'd1;
    else div_cnt <= '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fwd(input string tag);
`ifdef ES_RESULT_BYPASS_EN
    chk({tag, "_fv"}, 32'(es_fwd_valid), 32'(es_to_ms_valid & (es_dest != 0)));
    chk({tag, "_fd"}, es_fwd_data, es_result);
`else
    chk({tag, "_fv"}, 32'(es_fwd_valid), 32'd0);
    chk({tag, "_fd"}, es_fwd_data, 32'd0);
`endif
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d,
                       input logic [31:0] pc);
    ds_to_es_valid = 1'b1;
    ds_alu_op      = op;
    ds_src1        = a;
    ds_src2        = b;
    ds_dest        = d;
    ds_pc          = pc;
    #1;
  endtask

  int n;
  logic saw_valid;

  initial begin
    reset = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_alu_op = '0;
    ds_src1 = '0;
    ds_src2 = '0;
    ds_dest = '0;
    ds_pc = '0;
    ms_allowin = 1'b1;
    wb_ex = 1'b0;
    wb_ertn_flush = 1'b0;
    wb_need_refetch = 1'b0;

    // Reset state
    tick;
    tick;
    chk("rst_allowin", 32'(es_allowin), 32'd1);
    chk("rst_valid", 32'(es_to_ms_valid), 32'd0);
    chk("rst_aluop", 32'(es_alu_op), 32'd0);
    chk("rst_fwd", 32'(es_fwd_valid), 32'd0);
    chk("rst_pc", es_pc, 32'd0);
    reset = 1'b0;
    tick;

    // add 5+7, single-cycle latency
    offer(OP_ADD, 32'd5, 32'd7, 5'd3, 32'h100);
    chk("add_allowin0", 32'(es_allowin), 32'd1);
    tick;
    ds_to_es_valid = 1'b0;
    #1;
    chk("add_valid", 32'(es_to_ms_valid), 32'd1);
    chk("add_result", es_result, 32'd12);
    chk("add_allowin1", 32'(es_allowin), 32'd1);
    chk("add_dest", 32'(es_dest), 32'd3);
    chk("add_pc", es_pc, 32'h100);
    chk_fwd("add");
    tick;
    chk("add_idle_valid", 32'(es_to_ms_valid), 32'd0);
    chk("add_allowin2", 32'(es_allowin), 32'd1);

    // divu 100/7 with memory stage stalled at the ready pulse
    ms_allowin = 1'b0;
    offer(OP_DIVU, 32'd100, 32'd7, 5'd4, 32'h104);
    tick;
    ds_to_es_valid = 1'b0;
    #1;
    chk("divu_op", 32'(es_alu_op), 32'(OP_DIVU));
    chk("divu_busy_allowin", 32'(es_allowin), 32'd0);
    n = 0;
    while (!es_to_ms_valid && n < 20) begin
      tick;
      n++;
    end
    chk("divu_latency", 32'(n), 32'(DIV_LAT - 1));
    chk("divu_result_busy", es_result, 32'd14);
    tick;
    chk("divu_done_valid", 32'(es_to_ms_valid), 32'd1);
    chk("divu_done_result", es_result, 32'd14);
    chk("divu_done_op", 32'(es_alu_op), 32'd0);
    tick;
    chk("divu_hold_result", es_result, 32'd14);
    ms_allowin = 1'b1;
    #1;
    chk("divu_release_allowin", 32'(es_allowin), 32'd1);
    chk("divu_release_valid", 32'(es_to_ms_valid), 32'd1);
    tick;
    chk("divu_after_valid", 32'(es_to_ms_valid), 32'd0);

    // Flush mid-divu: drain, ignore ds input, then a fresh divu
    offer(OP_DIVU, 32'd50, 32'd3, 5'd5, 32'h108);
    tick;
    ds_to_es_valid = 1'b0;
    tick;
    tick;
    tick;
    wb_ex = 1'b1;
    #1;
    chk("fl_valid_during", 32'(es_to_ms_valid), 32'd0);
    tick;
    wb_ex = 1'b0;
    offer(OP_ADD, 32'd1, 32'd1, 5'd6, 32'h10c);
    chk("drain_allowin", 32'(es_allowin), 32'd0);
    chk("drain_op", 32'(es_alu_op), 32'(OP_DIVU));
    tick;
    ds_to_es_valid = 1'b0;
    #1;
    chk("drain_no_accept", es_alu_src1, 32'd50);
    n = 1;
    saw_valid = 1'b0;
    while (!es_allowin && n < 20) begin
      saw_valid |= es_to_ms_valid;
      tick;
      n++;
    end
    chk("drain_len", 32'(n), 32'd4);
    chk("drain_no_valid", 32'(saw_valid), 32'd0);
    chk("drain_idle_op", 32'(es_alu_op), 32'd0);
    offer(OP_DIVU, 32'd9, 32'd2, 5'd7, 32'h110);
    tick;
    ds_to_es_valid = 1'b0;
    n = 0;
    while (!es_to_ms_valid && n < 20) begin
      tick;
      n++;
    end
    chk("divu2_latency", 32'(n), 32'(DIV_LAT - 1));
    chk("divu2_result", es_result, 32'd4);
    tick;

    // Flush mid signed div: straight to IDLE, next op is clean
    offer(OP_DIV, 32'hFFFF_FFF7, 32'd2, 5'd8, 32'h114);
    tick;
    ds_to_es_valid = 1'b0;
    tick;
    tick;
    wb_ex = 1'b1;
    #1;
    chk("sdiv_fl_valid", 32'(es_to_ms_valid), 32'd0);
    tick;
    wb_ex = 1'b0;
    #1;
    chk("sdiv_idle_allowin", 32'(es_allowin), 32'd1);
    chk("sdiv_idle_op", 32'(es_alu_op), 32'd0);
    offer(OP_OR, 32'h0F, 32'hF0, 5'd9, 32'h118);
    tick;
    ds_to_es_valid = 1'b0;
    #1;
    chk("or_valid", 32'(es_to_ms_valid), 32'd1);
    chk("or_result", es_result, 32'hFF);
    tick;

    // Back-to-back adds, no bubbles
    offer(OP_ADD, 32'd1, 32'd2, 5'd10, 32'h200);
    tick;
    offer(OP_ADD, 32'd10, 32'd20, 5'd11, 32'h204);
    chk("b2b_v0", 32'(es_to_ms_valid), 32'd1);
    chk("b2b_r0", es_result, 32'd3);
    chk("b2b_a0", 32'(es_allowin), 32'd1);
    tick;
    offer(OP_ADD, 32'd100, 32'd200, 5'd0, 32'h208);
    chk("b2b_v1", 32'(es_to_ms_valid), 32'd1);
    chk("b2b_r1", es_result, 32'd30);
    chk("b2b_d1", 32'(es_dest), 32'd11);
    chk_fwd("b2b1");
    tick;
    ds_to_es_valid = 1'b0;
    #1;
    chk("b2b_v2", 32'(es_to_ms_valid), 32'd1);
    chk("b2b_r2", es_result, 32'd300);
    chk_fwd("b2b2");
    tick;
    chk("b2b_end", 32'(es_to_ms_valid), 32'd0);

    // Reset mid-divu
    offer(OP_DIVU, 32'd100, 32'd7, 5'd12, 32'h300);
    tick;
    ds_to_es_valid = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    chk("rdiv_busy_op", 32'(es_alu_op), 32'(OP_DIVU));
    tick;
    chk("rdiv_allowin", 32'(es_allowin), 32'd1);
    chk("rdiv_op", 32'(es_alu_op), 32'd0);
    chk("rdiv_valid", 32'(es_to_ms_valid), 32'd0);
    chk("rdiv_dest", 32'(es_dest), 32'd0);
    chk("rdiv_src1", es_alu_src1, 32'd0);
    reset = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
